// File: rtl/eq_serial_ctrl.sv
// Bit-serial MSB-first comparator built around a single 1-bit equality cell.
// Yields eq/gt/lt for two WIDTH-bit operands through a start/ready/done handshake.

module eq1 (
   input  logic x,
   input  logic y,
   output logic eq
);
   assign eq = ~(x ^ y);
endmodule

module eq_serial_ctrl #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sh_a_q, sh_b_q;
   logic [CW-1:0]    cnt_q;
   logic             mm_q;
   logic             ready_q, busy_q, done_q;
   logic             eq_q, gt_q, lt_q;

   logic bit_eq;
   logic first_mm;

   eq1 u_eq1 (
      .x  (sh_a_q[WIDTH-1]),
      .y  (sh_b_q[WIDTH-1]),
      .eq (bit_eq)
   );

   // Only the first mismatching bit decides magnitude.
   assign first_mm = ~bit_eq & ~mm_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         cnt_q   <= '0;
         mm_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sh_a_q  <= a;
                  sh_b_q  <= b;
                  cnt_q   <= CNT_LOAD;
                  mm_q    <= 1'b0;
                  eq_q    <= 1'b0;
                  gt_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (first_mm) begin
                  mm_q <= 1'b1;
                  gt_q <= sh_a_q[WIDTH-1];
                  lt_q <= sh_b_q[WIDTH-1];
               end
               if (first_mm && (EARLY_EXIT != 0)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  sh_a_q <= {sh_a_q[WIDTH-2:0], 1'b0};
                  sh_b_q <= {sh_b_q[WIDTH-2:0], 1'b0};
                  if (cnt_q == '0) begin
                     // Last bit: equal only if no earlier and no current mismatch.
                     eq_q    <= ~mm_q & bit_eq;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign eq    = eq_q;
   assign gt    = gt_q;
   assign lt    = lt_q;

endmodule

// File: doc/eq_serial_ctrl.md
Name: eq_serial_ctrl

Overview:
Sequencer that time-shares one eq1 single-bit equality cell to compare two WIDTH-bit operands bit-serially, MSB first. It also derives magnitude (gt/lt) from the first mismatching bit. It is used in the ALU compare path where area beats latency, with a start/ready/done handshake toward the ALU control FSM.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32
EARLY_EXIT, 1, 1 = finish on first mismatching bit; 0 = always scan all WIDTH bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse: results valid
eq  output  1  a == b
gt  output  1  a > b (unsigned)
lt  output  1  a < b (unsigned)

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n; it is sampled only on the rising edge of clk.
- Exactly one eq1 instance performs all bit compares. Its inputs are sh_a[WIDTH-1] and sh_b[WIDTH-1]; no other equality logic is allowed.
- Internal state: 2-bit state (IDLE, RUN, DONE), shift registers sh_a and sh_b, bit counter cnt of $clog2(WIDTH) bits, mismatch flag mm.
- Reset (rst_n=0 at an edge): state=IDLE; ready=1; busy=0, done=0, eq=0, gt=0, lt=0; mm=0. Reset overrides every other event, including mid-RUN.
- IDLE, start=1: load sh_a=a and sh_b=b; set cnt=WIDTH-1; clear eq/gt/lt/mm; go to RUN.
- IDLE, start=0: hold state; results hold their last values.
- RUN, each edge, on the current MSB pair:
  - If eq1 output is 0 and mm=0: set mm=1, gt=sh_a[MSB], lt=sh_b[MSB].
  - If EARLY_EXIT=1, go to DONE on that same edge.
- RUN, otherwise: shift sh_a and sh_b left by one and decrement cnt.
  - If cnt==0 on this edge, go to DONE.
  - On entering DONE with mm=0, set eq=1.
- Later mismatches after the first never change gt/lt (EARLY_EXIT=0 case).
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- eq/gt/lt hold their values until the next accepted start. Exactly one of eq/gt/lt is 1 after any completed compare.
- start is ignored in RUN and DONE. Operand changes after acceptance have no effect.
- Latency, with accept at edge 0:
  - Full scan: DONE entered at edge WIDTH; done high in the cycle after edge WIDTH.
  - Early exit at bit j: DONE entered at edge WIDTH-j.
  - Back-to-back minimum period: WIDTH+2 cycles.
- cnt never wraps. RUN always exits at cnt==0.
- start held high continuously re-triggers on each IDLE cycle; this is legal.

Test Plan (WIDTH=8):
- EARLY_EXIT=1, a=0xA5, b=0xA5 -> done high in the cycle after edge 8; eq=1, gt=0, lt=0; ready returns 1 one cycle later.
- EARLY_EXIT=1, a=0x80, b=0x00 -> mismatch at bit7; done in the cycle after edge 1; gt=1, eq=0, lt=0.
- EARLY_EXIT=1, a=0x12, b=0x13 -> mismatch at bit0; done in the cycle after edge 8; lt=1.
- EARLY_EXIT=0, a=0x4F, b=0x30 -> done in the cycle after edge 8 (no early exit); gt=1 from bit6 despite b>a in no later bit override; lt=0.
- start re-pulsed at edge 3 of RUN with a=b=0xFF, original a=0x01, b=0x02 -> ignored; result lt=1; exactly one done pulse.
- rst_n=0 at edge 3 of RUN -> next cycle ready=1, busy=0, done=0, eq=gt=lt=0. A new start with a=b=0x3C then completes normally with eq=1.
